// File: rtl/daq_dma_pkg.sv
// Shared constants for the DAQ DMA writer: register map, STAT/CTRL bit positions
// and the master FSM state encoding.
package daq_dma_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_BASE = 2'd1;
  localparam logic [1:0] REG_SIZE = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_WRAP   = 1;
  localparam int CTRL_CLEAR  = 2;

  localparam int STAT_OVERFLOW   = 24;
  localparam int STAT_WRAPPED    = 25;
  localparam int STAT_DONE       = 26;
  localparam int STAT_FIFO_EMPTY = 27;
  localparam int STAT_BUSY       = 28;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_e;

endpackage

// File: rtl/daq_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the oldest word while not empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module daq_fifo
  import daq_dma_pkg::*;
#(
  parameter int AW     = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              w_do_push;
  logic              w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign rdata     = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/daq_dma_writer.sv
// DAQ word stream to SDRAM writer: register file, run enable, input FIFO and
// an Avalon-MM write master filling a linear or ring buffer.
module daq_dma_writer
  import daq_dma_pkg::*;
#(
  parameter int FIFO_AW = 6,
  parameter int SIZE_W  = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        daq_write,
  input  logic [15:0] daq_writedata,
  output logic        daq_running,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [15:0] avm_writedata,
  input  logic        avm_waitrequest
);

  wr_state_e          r_state;
  wr_state_e          w_state_nxt;
  logic               r_enable;
  logic               r_wrap;
  logic               r_clear_pend;
  logic [31:0]        r_base;
  logic [SIZE_W-1:0]  r_size;
  logic [SIZE_W-1:0]  r_wptr;
  logic               r_overflow;
  logic               r_wrapped;
  logic               r_done;
  logic               r_running;
  logic [31:0]        r_readdata;
  logic [31:0]        r_avm_address;
  logic               r_avm_write;
  logic [15:0]        r_avm_writedata;

  logic               w_pop;
  logic               w_complete;
  logic               w_clear_apply;
  logic               w_push;
  logic               w_flush;
  logic               w_overflow;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [15:0]        w_fifo_rdata;
  logic [SIZE_W-1:0]  w_wptr_inc;
  logic               w_hit_end;
  logic [31:0]        w_byte_off;
  logic [31:0]        w_stat;

  assign daq_running   = r_running;
  assign avs_readdata  = r_readdata;
  assign avm_address   = r_avm_address;
  assign avm_write     = r_avm_write;
  assign avm_writedata = r_avm_writedata;

  assign w_wptr_inc = r_wptr + SIZE_W'(1);
  assign w_hit_end  = (w_wptr_inc == r_size);
  assign w_byte_off = {{(31-SIZE_W){1'b0}}, r_wptr, 1'b0};

  // Words that slip in during the cycle DONE rises are flushed, never written.
  assign w_push     = daq_write && r_running;
  assign w_flush    = w_clear_apply || r_done;
  assign w_overflow = w_push && w_fifo_full && !w_pop;

  daq_fifo #(
    .AW     (FIFO_AW),
    .DATA_W (16)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (w_push),
    .wdata (daq_writedata),
    .pop   (w_pop),
    .flush (w_flush),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  always_comb begin
    w_stat                  = '0;
    w_stat[SIZE_W-1:0]      = r_wptr;
    w_stat[STAT_OVERFLOW]   = r_overflow;
    w_stat[STAT_WRAPPED]    = r_wrapped;
    w_stat[STAT_DONE]       = r_done;
    w_stat[STAT_FIFO_EMPTY] = w_fifo_empty;
    w_stat[STAT_BUSY]       = (r_state == ST_WRITE) || !w_fifo_empty;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // A pending CLEAR waits for IDLE so an Avalon transfer is never cut short.
  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_complete    = 1'b0;
    w_clear_apply = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_clear_pend) begin
          w_clear_apply = 1'b1;
        end else if (!w_fifo_empty && !r_done) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!avm_waitrequest) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable     <= 1'b0;
      r_wrap       <= 1'b0;
      r_clear_pend <= 1'b0;
      r_base       <= '0;
      r_size       <= '0;
      r_wptr       <= '0;
      r_overflow   <= 1'b0;
      r_wrapped    <= 1'b0;
      r_done       <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      if (avs_write) begin
        case (avs_address)
          REG_CTRL: begin
            r_enable <= avs_writedata[CTRL_ENABLE];
            r_wrap   <= avs_writedata[CTRL_WRAP];
            if (avs_writedata[CTRL_CLEAR]) r_clear_pend <= 1'b1;
          end
          REG_BASE: if (!r_running) r_base <= {avs_writedata[31:1], 1'b0};
          REG_SIZE: r_size <= avs_writedata[SIZE_W-1:0];
          default: ;
        endcase
      end

      if (w_clear_apply) begin
        r_clear_pend <= 1'b0;
        r_wptr       <= '0;
        r_overflow   <= 1'b0;
        r_wrapped    <= 1'b0;
        r_done       <= 1'b0;
      end else begin
        if (w_overflow) r_overflow <= 1'b1;
        if (w_complete) begin
          if (w_hit_end && r_wrap) begin
            r_wptr    <= '0;
            r_wrapped <= 1'b1;
          end else begin
            r_wptr <= w_wptr_inc;
            if (w_hit_end) r_done <= 1'b1;
          end
        end
      end

      // Holding the run off while CLEAR is pending makes a new run start at WPTR=0.
      r_running <= r_enable && !r_done && (r_size != '0) && !r_clear_pend;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avm_write     <= 1'b0;
      r_avm_address   <= '0;
      r_avm_writedata <= '0;
    end else if (w_pop) begin
      r_avm_write     <= 1'b1;
      r_avm_address   <= r_base + w_byte_off;
      r_avm_writedata <= w_fifo_rdata;
    end else if (w_complete) begin
      r_avm_write <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        REG_CTRL: r_readdata <= {29'd0, 1'b0, r_wrap, r_enable};
        REG_BASE: r_readdata <= r_base;
        REG_SIZE: r_readdata <= {{(32-SIZE_W){1'b0}}, r_size};
        default:  r_readdata <= w_stat;
      endcase
    end
  end

endmodule
